// File: rtl/radical_n.sv
// Integer n-th root: d_out = floor(n1^(1/n2)) by binary search, each candidate checked by iterated multiply.
// Latency: valid_out in the 2nd cycle after acceptance on fast paths; search path 14 rounds of (n2+2) cycles max.
// Backpressure: none; valid_in is honoured only in IDLE and dropped while busy (not queued).
module radical_n #(
    parameter int MAX_VAL = 99999999,
    parameter int HI_INIT = 10000,
    parameter int DEG_SAT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] n1,
    input  logic [27:0] n2,
    input  logic        valid_in,
    output logic        valid_out,
    output logic        ovrflow,
    output logic [27:0] d_out,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SEARCH, POW, CMP, DONE} state_t;

    localparam logic signed [27:0] MAX_S = 28'(MAX_VAL);
    localparam logic signed [27:0] DEG_S = 28'(DEG_SAT);
    localparam logic [13:0]        HI_W  = 14'(HI_INIT);

    state_t      state;
    logic [27:0] n1_q;
    logic [4:0]  n2_q;
    logic [13:0] lo;
    logic [13:0] hi;
    logic [13:0] mid;
    logic [63:0] acc;
    logic [4:0]  k;

    logic signed [27:0] n1_s;
    logic signed [27:0] n2_s;
    logic               in_err;
    logic               in_triv;
    logic               in_sat;
    logic [14:0]        mid_sum;
    logic [13:0]        mid_nxt;
    logic [63:0]        prod;
    logic [63:0]        n1_ext;

    assign n1_s    = $signed(n1);
    assign n2_s    = $signed(n2);
    assign in_err  = (n2_s <= 28'sd0) || (n1_s < 28'sd0) || (n1_s > MAX_S);
    assign in_triv = (n2_s == 28'sd1) || (n1_s == 28'sd0) || (n1_s == 28'sd1);
    assign in_sat  = (n2_s >= DEG_S);

    // Upper-biased midpoint so lo=mid always makes progress.
    assign mid_sum = {1'b0, lo} + {1'b0, hi} + 15'd1;
    assign mid_nxt = 14'(mid_sum >> 1);
    assign prod    = acc * {50'd0, mid};
    assign n1_ext  = {36'd0, n1_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            ovrflow   <= 1'b0;
            d_out     <= '0;
            busy      <= 1'b0;
            n1_q      <= '0;
            n2_q      <= '0;
            lo        <= '0;
            hi        <= '0;
            mid       <= '0;
            acc       <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        busy    <= 1'b1;
                        ovrflow <= 1'b0;
                        n1_q    <= n1;
                        // Only degrees 2..26 reach the search, so five bits suffice.
                        n2_q    <= n2[4:0];
                        if (in_err) begin
                            ovrflow <= 1'b1;
                            d_out   <= '1;
                            state   <= DONE;
                        end else if (in_triv) begin
                            d_out <= n1;
                            state <= DONE;
                        end else if (in_sat) begin
                            d_out <= 28'd1;
                            state <= DONE;
                        end else begin
                            lo    <= '0;
                            hi    <= HI_W;
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (lo == hi) begin
                        d_out <= {14'd0, lo};
                        state <= DONE;
                    end else begin
                        mid   <= mid_nxt;
                        acc   <= 64'd1;
                        k     <= '0;
                        state <= POW;
                    end
                end
                POW: begin
                    acc <= prod;
                    k   <= k + 5'd1;
                    if ((k + 5'd1 == n2_q) || (prod > n1_ext))
                        state <= CMP;
                end
                CMP: begin
                    if (acc <= n1_ext)
                        lo <= mid;
                    else
                        hi <= mid - 14'd1;
                    state <= SEARCH;
                end
                DONE: begin
                    // First DONE cycle arms the strobe, second cycle carries it.
                    if (!valid_out) begin
                        valid_out <= 1'b1;
                    end else begin
                        valid_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
